// File: rtl/sel_add_pkg.sv
// Shared encodings and stage-control layout for the select/add/accumulate block.
package sel_add_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_ACC = 1'b1;

  // Register stages between operand capture and result.
  localparam int STAGES = 2;

  // Per-beat control carried alongside the operands in S1.
  typedef struct packed {
    logic mode;
    logic clr;
    logic err;
  } s1_ctl_t;

endpackage

// File: rtl/sel_mux_n.sv
// NPAIR-to-1 operand pair selector; out-of-range selects yield zero operands.
module sel_mux_n #(
  parameter int WIDTH = 4,
  parameter int NPAIR = 2,
  parameter int SELW  = $clog2(NPAIR)
) (
  input  logic [SELW-1:0]        sel,
  input  logic [NPAIR*WIDTH-1:0] ops_a,
  input  logic [NPAIR*WIDTH-1:0] ops_b,
  output logic [WIDTH-1:0]       a,
  output logic [WIDTH-1:0]       b,
  output logic                   err
);

  // Pick pair sel; nothing matches when sel >= NPAIR, leaving A = B = 0.
  always_comb begin
    a = '0;
    b = '0;
    for (int i = 0; i < NPAIR; i++) begin
      if (32'(sel) == i) begin
        a = ops_a[i*WIDTH +: WIDTH];
        b = ops_b[i*WIDTH +: WIDTH];
      end
    end
  end

  assign err = (32'(sel) >= NPAIR);

endmodule

// File: rtl/sel_add_acc.sv
// Two-stage select/add/accumulate pipeline with valid/ready on both sides.
// S1 captures the selected pair and beat control; S2 adds (optionally onto
// the accumulator) and registers sum/carry/sel_err. Both stages advance
// together whenever the output register is empty or being drained.
module sel_add_acc
  import sel_add_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NPAIR = 2,
  parameter int SELW  = $clog2(NPAIR)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SELW-1:0]        sel,
  input  logic                   mode,
  input  logic                   clr_acc,
  input  logic [NPAIR*WIDTH-1:0] ops_a,
  input  logic [NPAIR*WIDTH-1:0] ops_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       sum,
  output logic                   carry,
  output logic                   sel_err
);

  logic                 advance;
  logic [STAGES:1]      vld_pipe;
  logic [WIDTH-1:0]     mux_a, mux_b;
  logic                 mux_err;
  logic [WIDTH-1:0]     s1_a, s1_b;
  s1_ctl_t              s1_ctl;
  logic [WIDTH-1:0]     acc;
  logic [WIDTH-1:0]     base;
  logic [WIDTH+1:0]     s2_tot;
  logic                 idle_clr;

  sel_mux_n #(.WIDTH(WIDTH), .NPAIR(NPAIR), .SELW(SELW)) u_mux (
    .sel   (sel),
    .ops_a (ops_a),
    .ops_b (ops_b),
    .a     (mux_a),
    .b     (mux_b),
    .err   (mux_err)
  );

  assign advance   = !vld_pipe[STAGES] || out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_pipe[STAGES];

  // A clear with no beat offered is a standalone command on the accumulator.
  assign idle_clr  = advance && !in_valid && clr_acc;

  // Mode-0 beats and cleared mode-1 beats add onto zero instead of acc.
  assign base   = (s1_ctl.mode == MODE_ACC && !s1_ctl.clr) ? acc : '0;
  assign s2_tot = {2'b00, base} + {2'b00, s1_a} + {2'b00, s1_b};

  // Valid shift register: moves as a whole only when the pipe advances.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          vld_pipe <= '0;
    else if (advance) vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
  end

  // S1: capture selected operands and beat control on acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_a   <= '0;
      s1_b   <= '0;
      s1_ctl <= '0;
    end else if (advance && in_valid) begin
      s1_a   <= mux_a;
      s1_b   <= mux_b;
      s1_ctl <= '{mode: mode, clr: clr_acc, err: mux_err};
    end
  end

  // S2: register the result; held while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum     <= '0;
      carry   <= 1'b0;
      sel_err <= 1'b0;
    end else if (advance && vld_pipe[1]) begin
      sum     <= s2_tot[WIDTH-1:0];
      carry   <= |s2_tot[WIDTH+1:WIDTH];
      sel_err <= s1_ctl.err;
    end
  end

  // Accumulator: updated as a beat enters S2. An idle clear arriving on the
  // same edge was issued after that beat, so it wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (idle_clr) begin
      acc <= '0;
    end else if (advance && vld_pipe[1]) begin
      if (s1_ctl.mode == MODE_ACC) acc <= s2_tot[WIDTH-1:0];
      else if (s1_ctl.clr)         acc <= '0;
    end
  end

endmodule

// File: tb/tb_sel_add_acc.sv
// Bench for sel_add_acc: directed scenarios plus randomized traffic checked
// against an in-order behavioural model of acceptances and clears.
module tb_sel_add_acc;

  localparam int W  = 4;
  localparam int NP = 3;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [SW-1:0]   sel;
  logic            mode;
  logic            clr_acc;
  logic [NP*W-1:0] ops_a;
  logic [NP*W-1:0] ops_b;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    sum;
  logic            carry;
  logic            sel_err;

  int total = 0;
  int bad   = 0;

  // {sel_err, carry, sum}
  logic [W+1:0] exp_q[$];
  logic [W+1:0] got_q[$];
  int           m_acc;

  sel_add_acc #(.WIDTH(W), .NPAIR(NP)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .mode      (mode),
    .clr_acc   (clr_acc),
    .ops_a     (ops_a),
    .ops_b     (ops_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry     (carry),
    .sel_err   (sel_err)
  );

  always #5 clk = ~clk;

  // Reference model: every accepted beat or idle clear is applied in the
  // order it was issued; results are expected in that same order.
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_acc = 0;
    end else begin
      if (in_ready && in_valid) begin
        int  oa, ob, t;
        bit  e;
        e  = (int'(sel) >= NP);
        oa = 0;
        ob = 0;
        if (!e) begin
          oa = int'(ops_a[int'(sel)*W +: W]);
          ob = int'(ops_b[int'(sel)*W +: W]);
        end
        if (mode == 1'b0) begin
          t = oa + ob;
          if (clr_acc) m_acc = 0;
        end else begin
          t = (clr_acc ? 0 : m_acc) + oa + ob;
          m_acc = t % (1 << W);
        end
        exp_q.push_back({e, (t >= (1 << W)), W'(t % (1 << W))});
      end else if (in_ready && clr_acc) begin
        m_acc = 0;
      end
      if (out_valid && out_ready) got_q.push_back({sel_err, carry, sum});
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [SW-1:0] s, input logic m, input logic c,
                      input logic [W-1:0] a, input logic [W-1:0] b);
    bit ok;
    ops_a = (NP*W)'($urandom);
    ops_b = (NP*W)'($urandom);
    if (int'(s) < NP) begin
      ops_a[int'(s)*W +: W] = a;
      ops_b[int'(s)*W +: W] = b;
    end
    sel = s; mode = m; clr_acc = c; in_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL send_accept: in_ready never seen high within 100 cycles");
    end
    in_valid = 1'b0;
    clr_acc  = 1'b0;
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 300 && !ok; k++) begin
      if (got_q.size() == exp_q.size() && !out_valid) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; clr_acc = 1'b0; sel = '0; mode = 1'b0;
    ops_a = '0; ops_b = '0; out_ready = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total++; if (sum !== '0)         begin bad++; $display("FAIL reset_sum: got %0d want 0", sum); end
    total++; if ({carry, sel_err} !== 2'b00) begin bad++; $display("FAIL reset_flags: got %b want 00", {carry, sel_err}); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    got_q.delete();
  endtask

  task automatic test_add();
    bit ok;
    got_q.delete();
    send(2'd0, 1'b0, 1'b0, 4'd3, 4'd4);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL add_latency_early: out_valid got %b want 0", out_valid); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL add_latency: out_valid got %b want 1", out_valid); end
    total++; if ({sel_err, carry, sum} !== 6'h07) begin bad++; $display("FAIL add_3_4: got %h want 07", {sel_err, carry, sum}); end
    send(2'd1, 1'b0, 1'b0, 4'd9, 4'd8);
    drain(ok);
    total++; if (!ok) begin bad++; $display("FAIL add_drain: got %0d results want %0d", got_q.size(), exp_q.size()); end
    total++; if (got_q.size() != 2 || got_q[1] !== 6'h11) begin bad++; $display("FAIL add_9_8: got n=%0d want n=2 last=11", got_q.size()); end
  endtask

  task automatic test_accum();
    bit ok;
    logic [W+1:0] want [3];
    want[0] = 6'h05; want[1] = 6'h0F; want[2] = 6'h02;
    exp_q.delete(); got_q.delete();
    send(2'd0, 1'b1, 1'b0, 4'd2, 4'd3);
    send(2'd1, 1'b1, 1'b0, 4'd5, 4'd5);
    send(2'd2, 1'b1, 1'b1, 4'd1, 4'd1);
    drain(ok);
    total++; if (!ok || got_q.size() != 3) begin bad++; $display("FAIL accum_count: got %0d want 3", got_q.size()); end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== want[i]) begin bad++; $display("FAIL accum[%0d]: got %h want %h", i, got_q[i], want[i]); end
    end
  endtask

  task automatic test_stall();
    bit ok;
    exp_q.delete(); got_q.delete();
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++)
          send(SW'($urandom_range(0, 2)), 1'b0, 1'b0, W'($urandom), W'($urandom));
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready: got %b want 0", in_ready); end
        total++; if (!out_valid || {sel_err, carry, sum} !== exp_q[0]) begin bad++; $display("FAIL stall_hold_a: got %b/%h want 1/%h", out_valid, {sel_err, carry, sum}, exp_q[0]); end
        @(posedge clk);
        #1;
        total++; if (!out_valid || {sel_err, carry, sum} !== exp_q[0]) begin bad++; $display("FAIL stall_hold_b: got %b/%h want 1/%h", out_valid, {sel_err, carry, sum}, exp_q[0]); end
        out_ready = 1'b1;
      end
    join
    drain(ok);
    total++; if (!ok || got_q.size() != 4 || exp_q.size() != 4) begin bad++; $display("FAIL stall_count: got %0d want 4", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL stall[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_selerr();
    bit ok;
    exp_q.delete(); got_q.delete();
    send(2'd3, 1'b0, 1'b0, W'($urandom), W'($urandom));
    send(2'd2, 1'b0, 1'b0, 4'd6, 4'd7);
    drain(ok);
    total++; if (!ok || got_q.size() != 2) begin bad++; $display("FAIL selerr_count: got %0d want 2", got_q.size()); end
    else begin
      total++; if (got_q[0] !== 6'h20) begin bad++; $display("FAIL selerr_oob: got %h want 20", got_q[0]); end
      total++; if (got_q[1] !== 6'h0D) begin bad++; $display("FAIL selerr_pair2: got %h want 0d", got_q[1]); end
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    exp_q.delete(); got_q.delete();
    send(2'd0, 1'b1, 1'b0, 4'd7, 4'd6);
    send(2'd1, 1'b1, 1'b0, 4'd5, 4'd4);
    send(2'd2, 1'b1, 1'b0, 4'd3, 4'd2);
    #2 rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
    total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
    @(posedge clk);
    #1 rst = 1'b0;
    got_q.delete();
    send(2'd0, 1'b1, 1'b0, 4'd1, 4'd2);
    drain(ok);
    total++; if (!ok || got_q.size() != 1 || got_q[0] !== 6'h03) begin bad++; $display("FAIL midrst_accum: got n=%0d want n=1 value 03", got_q.size()); end
  endtask

  task automatic test_random();
    bit ok;
    bit done;
    exp_q.delete(); got_q.delete();
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          int g;
          g = $urandom_range(0, 2);
          repeat (g) begin
            clr_acc = ($urandom_range(0, 3) == 0);
            @(posedge clk);
            #1;
          end
          clr_acc = 1'b0;
          send(SW'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0), W'($urandom), W'($urandom));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = ($urandom_range(0, 2) != 0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain(ok);
    total++; if (!ok || got_q.size() != exp_q.size()) begin bad++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_accum();
    test_stall();
    test_selerr();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sel_add_acc.md
SEL_ADD_ACC -- requirements
Module: sel_add_acc

Interface
REQ-001 SHALL have parameter WIDTH, default 4, the operand and sum width in bits (legal range 2..32).
REQ-002 SHALL have parameter NPAIR, default 2, the number of selectable operand pairs (legal range 2..16).
REQ-003 SHALL have parameter SELW, default $clog2(NPAIR), the width of the select field.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1, meaning an operand beat is offered.
REQ-007 SHALL have port in_ready, output, 1, meaning the block accepts a beat this cycle.
REQ-008 SHALL have port sel, input, SELW, the index of the operand pair to use.
REQ-009 SHALL have port mode, input, 1: 0 = plain add, 1 = accumulate.
REQ-010 SHALL have port clr_acc, input, 1, a synchronous accumulator clear.
REQ-011 SHALL have port ops_a, input, NPAIR*WIDTH, the A operands; pair i occupies bits [i*WIDTH +: WIDTH].
REQ-012 SHALL have port ops_b, input, NPAIR*WIDTH, the B operands, packed the same way as ops_a.
REQ-013 SHALL have port out_valid, output, 1, meaning the result is valid.
REQ-014 SHALL have port out_ready, input, 1, meaning the consumer accepts the result.
REQ-015 SHALL have port sum, output, WIDTH, the result modulo 2^WIDTH.
REQ-016 SHALL have port carry, output, 1, the carry out of the WIDTH-bit addition that produced sum.
REQ-017 SHALL have port sel_err, output, 1, meaning sel was >= NPAIR for this result.

Function
REQ-018 SHALL be a two-stage pipeline: S1 registers the selected pair plus mode, clr_acc and sel_err; S2 computes and registers sum, carry and sel_err.
REQ-019 SHALL define advance = !out_valid || out_ready, and SHALL drive in_ready = advance combinationally.
REQ-020 SHALL accept a beat when in_valid && in_ready.
REQ-021 SHALL hold both stages unchanged when advance = 0, with no loss or duplication of beats.
REQ-022 SHALL make the accepted result visible on out_valid exactly 2 cycles after acceptance when out_ready is held high.
REQ-023 SHALL sustain one result per cycle when out_ready is held high.
REQ-024 SHALL, in mode 0, produce {carry,sum} = A + B, computed at WIDTH+1 bits.
REQ-025 SHALL, in mode 1, produce {carry,sum} = acc + A + B, computed at WIDTH+2 bits; carry is set if that total >= 2^WIDTH; acc then takes the new sum.
REQ-026 SHALL leave acc unchanged for mode-0 beats.
REQ-027 SHALL apply clr_acc on an accepted mode-1 beat by treating acc as 0 for that beat.
REQ-028 SHALL apply clr_acc on an accepted mode-0 beat by setting acc to 0 when the beat enters S2.
REQ-029 SHALL, on clr_acc with in_valid low while in_ready = 1, set acc to 0 on the next edge.
REQ-030 SHALL, when sel >= NPAIR, use operands A = B = 0 and set sel_err = 1 for that result.
REQ-031 SHALL hold sum, carry and sel_err stable while out_valid && !out_ready.

Reset
REQ-032 SHALL, on rst, clear both stage valid flags, out_valid, sum, carry, sel_err and acc to 0, immediately and independent of clk.
REQ-033 SHALL discard any in-flight beats on a mid-operation reset.
REQ-034 SHALL drive in_ready = 1 during and after reset.

Structure
REQ-035 SHALL place the mode encodings (MODE_ADD = 0, MODE_ACC = 1) in the shared package sel_add_pkg.
REQ-036 SHALL place one sub-module, sel_mux_n (a parametrised NPAIR-to-1 WIDTH-bit selector with an out-of-range flag), in front of S1.

Verification (WIDTH=4, NPAIR=2)
REQ-037 Scenario: sel=0, a0=3, b0=4, mode=0 -> 2 cycles later sum=7, carry=0, sel_err=0.
REQ-038 Scenario: sel=1, a1=9, b1=8, mode=0 -> sum=1, carry=1.
REQ-039 Scenario: mode=1 beats (2,3), (5,5), then clr_acc with (1,1) -> sums 5, 15 (carry 0), then 2.
REQ-040 Scenario: out_ready=0 for 3 cycles with 4 beats offered -> in_ready falls and the 4 results arrive in order, none lost or duplicated.
REQ-041 Scenario: a sel out of range is not reachable with NPAIR=2; use NPAIR=3 with sel=3 -> sum=0, sel_err=1.
REQ-042 Scenario: assert rst while S1 and S2 are full -> out_valid=0 immediately and acc=0; the next accum beat (1,2) gives sum=3.
